mem_arbiter: RTL and testbench

Sequences and shares the single multi-cycle main memory between the instruction-cache fill path and the data-cache fill/write-through path. Each cache presents one request; the arbiter grants one owner, issues either an 8-beat block read or a single-word write to memory, and routes returned beats back to the owner. It sits between the cache controller's miss logic and the multi-cycle memory, replacing direct shared wiring of the memory enable, address and write lines.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_beat_counter.sv | 40 ++++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D main-memory arbiter: FSM states, owner encoding, burst geometry.
package mem_arb_pkg;

   localparam int BEATS_LOG2 = 3;
   localparam int BLK_OFF_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_WRITE = 2'd3
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arb_beat_counter.sv
// Beat counter: clear wins over increment, wraps modulo 2**BEATS_LOG2, flags LAST.
// Registered count; no backpressure, advances whenever inc is high.
module mem_arb_beat_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LAST = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  inc,
   output logic [BEATS_LOG2-1:0] cnt,
   output logic                  tc
);

   localparam logic [BEATS_LOG2-1:0] LAST_C = BEATS_LOG2'(LAST);

   logic [BEATS_LOG2-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + BEATS_LOG2'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == LAST_C);

endmodule

// File: rtl/mem_arbiter.sv
// Shares main memory between I-fill and D-fill/write-through; grant one cycle after request, returns routed combinationally.
// No backpressure toward memory; MEM_ARB_ROUND_ROBIN_EN swaps fixed D priority for alternating priority on contention.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BEATS  = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  i_req,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic                  i_gnt,
   output logic                  i_vld,
   output logic [DATA_W-1:0]     i_data,
   output logic [BEATS_LOG2-1:0] i_beat,
   output logic                  i_done,

   input  logic                  d_req,
   input  logic                  d_wr,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic                  d_gnt,
   output logic                  d_vld,
   output logic [DATA_W-1:0]     d_data,
   output logic [BEATS_LOG2-1:0] d_beat,
   output logic                  d_done,

   output logic                  mem_en,
   output logic                  mem_wr,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_vld,

   output logic                  busy
);

   state_e                     state_q, state_d;
   owner_e                     owner_q, owner_d;
   logic [ADDR_W-1:BLK_OFF_W]  base_q, base_d;

   logic [BEATS_LOG2-1:0]      issue_cnt, ret_cnt;
   logic                       issue_tc, ret_tc;
   logic                       issue_inc, ret_inc, cnt_clr;
   logic                       in_read, ret_vld, last_beat, done_any;
   logic                       prio_d, pick_d;
   logic                       unused_addr_bits;

   // Block offset of an I miss is regenerated by the issue counter.
   assign unused_addr_bits = ^i_addr[BLK_OFF_W-1:0];

   assign in_read   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign ret_vld   = in_read && mem_vld;
   assign last_beat = ret_vld && ret_tc;
   assign done_any  = last_beat || (state_q == ST_WRITE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_e last_owner_q, last_owner_d;

   always_comb begin
      last_owner_d = last_owner_q;
      if (done_any) begin
         last_owner_d = owner_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner_q <= OWN_I;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end

   assign prio_d = (last_owner_q != OWN_D);
`else
   assign prio_d = 1'b1;
`endif

   assign pick_d = d_req && (!i_req || prio_d);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      base_d  = base_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_d) begin
               owner_d = OWN_D;
               base_d  = d_addr[ADDR_W-1:BLK_OFF_W];
               state_d = d_wr ? ST_WRITE : ST_ISSUE;
            end else if (i_req) begin
               owner_d = OWN_I;
               base_d  = i_addr[ADDR_W-1:BLK_OFF_W];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (last_beat) begin
               state_d = ST_IDLE;
            end else if (issue_tc) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (last_beat) begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_I;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         base_q  <= base_d;
      end
   end

   // Both counters restart from zero whenever the FSM heads back to IDLE.
   assign cnt_clr   = (state_d == ST_IDLE);
   assign issue_inc = (state_q == ST_ISSUE);
   assign ret_inc   = ret_vld;

   mem_arb_beat_counter #(.LAST(BEATS - 1)) u_issue_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (issue_inc),
      .cnt (issue_cnt),
      .tc  (issue_tc)
   );

   mem_arb_beat_counter #(.LAST(BEATS - 1)) u_ret_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (ret_inc),
      .cnt (ret_cnt),
      .tc  (ret_tc)
   );

   always_comb begin
      busy      = (state_q != ST_IDLE);
      i_gnt     = busy && (owner_q == OWN_I);
      d_gnt     = busy && (owner_q == OWN_D);

      i_vld     = ret_vld && (owner_q == OWN_I);
      d_vld     = ret_vld && (owner_q == OWN_D);
      i_data    = i_vld ? mem_rdata : '0;
      d_data    = d_vld ? mem_rdata : '0;
      i_beat    = i_vld ? ret_cnt : '0;
      d_beat    = d_vld ? ret_cnt : '0;
      i_done    = last_beat && (owner_q == OWN_I);
      d_done    = (last_beat && (owner_q == OWN_D)) || (state_q == ST_WRITE);

      mem_en    = (state_q == ST_ISSUE) || (state_q == ST_WRITE);
      mem_wr    = (state_q == ST_WRITE);
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == ST_ISSUE) begin
         mem_addr = {base_q, issue_cnt, 1'b0};
      end else if (state_q == ST_WRITE) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter with a latency-programmable, optionally gapped memory model.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_gnt, i_vld, i_done;
   logic [15:0] i_data;
   logic [2:0]  i_beat;
   logic        d_req, d_wr;
   logic [15:0] d_addr, d_wdata;
   logic        d_gnt, d_vld, d_done;
   logic [15:0] d_data;
   logic [2:0]  d_beat;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_vld;
   logic        busy;

   int checks = 0;
   int errors = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   mem_arbiter #(.BEATS(8), .ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_vld(i_vld),
      .i_data(i_data), .i_beat(i_beat), .i_done(i_done),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_vld(d_vld), .d_data(d_data), .d_beat(d_beat), .d_done(d_done),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_vld(mem_vld), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   // Memory model: reads issued this cycle return lat cycles later, in order.
   typedef struct { logic [15:0] a; int due; } iss_t;
   iss_t pend[$];
   int   cyc = 0;
   int   lat = 4;
   bit   gap = 1'b0;
   bit   gap_ph = 1'b0;
   bit   stray = 1'b0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst) begin
         pend.delete();
         mem_vld   = 1'b0;
         mem_rdata = 16'h0;
      end else begin
         if (mem_en === 1'b1 && mem_wr === 1'b0) pend.push_back('{mem_addr, cyc + lat});
         gap_ph = ~gap_ph;
         if (stray) begin
            mem_vld   = 1'b1;
            mem_rdata = 16'hFFFF;
         end else if (pend.size() > 0 && pend[0].due <= cyc && (!gap || gap_ph)) begin
            mem_vld   = 1'b1;
            mem_rdata = mem_f(pend[0].a);
            void'(pend.pop_front());
         end else begin
            mem_vld   = 1'b0;
            mem_rdata = 16'h0;
         end
      end
   end

   typedef struct { bit own_d; logic [2:0] beat; logic [15:0] data; } sb_t;
   sb_t sb[$];

   task automatic push_burst(input bit own_d, input logic [15:0] addr);
      logic [2:0]  k;
      logic [15:0] a;
      for (int n = 0; n < 8; n++) begin
         k = 3'(n);
         a = {addr[15:4], k, 1'b0};
         sb.push_back('{own_d, k, mem_f(a)});
      end
   endtask

   // Runs one granted read burst to completion, checking issue, grant and returns.
   task automatic collect_burst(input bit own_d, input logic [15:0] base, input int max_cyc);
      int          n_iss, n_ret;
      bit          done_seen;
      sb_t         e;
      logic [15:0] exp_a;
      logic        own_gnt, oth_gnt, own_vld, oth_vld, own_done;
      logic [15:0] own_data;
      logic [2:0]  own_beat;
      n_iss = 0; n_ret = 0; done_seen = 1'b0;
      for (int c = 0; c < max_cyc && !done_seen; c++) begin
         @(negedge clk);
         own_gnt  = own_d ? d_gnt  : i_gnt;
         oth_gnt  = own_d ? i_gnt  : d_gnt;
         own_vld  = own_d ? d_vld  : i_vld;
         oth_vld  = own_d ? i_vld  : d_vld;
         own_done = own_d ? d_done : i_done;
         own_data = own_d ? d_data : i_data;
         own_beat = own_d ? d_beat : i_beat;
         checks++;
         if (own_gnt !== 1'b1 || oth_gnt !== 1'b0 || oth_vld !== 1'b0) begin
            errors++;
            $display("FAIL burst_gnt cyc%0d: own_gnt=%b oth_gnt=%b oth_vld=%b, required 1 0 0", c, own_gnt, oth_gnt, oth_vld);
         end
         if (mem_en === 1'b1) begin
            exp_a = base + 16'(2 * n_iss);
            checks++;
            if (c != n_iss || n_iss >= 8 || mem_wr !== 1'b0 || mem_addr !== exp_a) begin
               errors++;
               $display("FAIL burst_issue cyc%0d: issue#%0d wr=%b addr=%h, required cyc%0d wr=0 addr=%h", c, n_iss, mem_wr, mem_addr, n_iss, exp_a);
            end
            n_iss++;
         end
         if (own_vld === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL burst_beat: unexpected beat %0d data %h, scoreboard empty", own_beat, own_data);
            end else begin
               e = sb.pop_front();
               if (e.own_d != own_d || own_data !== e.data || own_beat !== e.beat) begin
                  errors++;
                  $display("FAIL burst_beat: side=%0d beat=%0d data=%h, required side=%0d beat=%0d data=%h", own_d, own_beat, own_data, e.own_d, e.beat, e.data);
               end
            end
            n_ret++;
         end
         if (own_done === 1'b1) begin
            done_seen = 1'b1;
            checks++;
            if (own_vld !== 1'b1 || n_ret != 8) begin
               errors++;
               $display("FAIL burst_done: vld=%b beats=%0d, required vld=1 beats=8", own_vld, n_ret);
            end
            if (own_d) d_req = 1'b0;
            else       i_req = 1'b0;
         end
      end
      checks++;
      if (!done_seen || n_iss != 8) begin
         errors++;
         $display("FAIL burst_complete: done=%b issues=%0d, required done=1 issues=8", done_seen, n_iss);
         i_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
         errors++;
         $display("FAIL turnaround: busy=%b i_gnt=%b d_gnt=%b, required 0 0 0", busy, i_gnt, d_gnt);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      i_req = 1'b0; i_addr = 16'h0;
      d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_en, mem_wr, i_gnt, d_gnt, i_vld, d_vld, i_done, d_done, busy} !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl: en,wr,ig,dg,iv,dv,id,dd,busy=%b, required all 0",
                  {mem_en, mem_wr, i_gnt, d_gnt, i_vld, d_vld, i_done, d_done, busy});
      end
      checks++;
      if ({mem_addr, mem_wdata, i_data, d_data, i_beat, d_beat} !== 70'b0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h idata=%h ddata=%h, required 0", mem_addr, mem_wdata, i_data, d_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_contention;
      lat = 4;
      i_addr = 16'h2000; d_addr = 16'h3458; d_wr = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      push_burst(1'b1, 16'h3458);
      collect_burst(1'b1, 16'h3450, 40);
      push_burst(1'b0, 16'h2000);
      collect_burst(1'b0, 16'h2000, 40);
   endtask

   task automatic test_i_read;
      lat = 4;
      i_addr = 16'h1234; i_req = 1'b1;
      push_burst(1'b0, 16'h1234);
      collect_burst(1'b0, 16'h1230, 40);
   endtask

   task automatic test_d_write;
      d_addr = 16'h0042; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0042 || mem_wdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL write_mem: en=%b wr=%b addr=%h wdata=%h, required 1 1 0042 beef", mem_en, mem_wr, mem_addr, mem_wdata);
      end
      checks++;
      if (d_done !== 1'b1 || d_gnt !== 1'b1 || i_gnt !== 1'b0 || d_vld !== 1'b0) begin
         errors++;
         $display("FAIL write_ctl: d_done=%b d_gnt=%b i_gnt=%b d_vld=%b, required 1 1 0 0", d_done, d_gnt, i_gnt, d_vld);
      end
      d_req = 1'b0; d_wr = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_en !== 1'b0 || d_done !== 1'b0) begin
         errors++;
         $display("FAIL write_end: busy=%b mem_en=%b d_done=%b, required 0 0 0", busy, mem_en, d_done);
      end
   endtask

   task automatic test_round_robin;
      bit win_d;
      win_d = !RR;
      lat = 3;
      i_addr = 16'h6600; d_addr = 16'h7710; d_wr = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      push_burst(win_d, win_d ? 16'h7710 : 16'h6600);
      collect_burst(win_d, win_d ? 16'h7710 : 16'h6600, 40);
      push_burst(!win_d, win_d ? 16'h6600 : 16'h7710);
      collect_burst(!win_d, win_d ? 16'h6600 : 16'h7710, 40);
   endtask

   task automatic test_gapped;
      lat = 2; gap = 1'b1;
      d_addr = 16'h0A00; d_wr = 1'b0; d_req = 1'b1;
      push_burst(1'b1, 16'h0A00);
      collect_burst(1'b1, 16'h0A00, 60);
      gap = 1'b0;
   endtask

   task automatic test_reset_mid_burst;
      bit  found;
      sb_t e;
      lat = 1;
      i_addr = 16'h4000; i_req = 1'b1;
      push_burst(1'b0, 16'h4000);
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         if (i_vld === 1'b1) begin
            e = sb.pop_front();
            checks++;
            if (i_data !== e.data || i_beat !== e.beat) begin
               errors++;
               $display("FAIL midrst_beat: beat=%0d data=%h, required beat=%0d data=%h", i_beat, i_data, e.beat, e.data);
            end
            if (i_beat === 3'd3) found = 1'b1;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL midrst_wait: beat 3 seen=%b, required 1", found);
      end
      rst = 1'b1; i_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_en, mem_wr, i_gnt, d_gnt, i_vld, d_vld, i_done, d_done, busy} !== 9'b0 ||
          mem_addr !== 16'h0 || i_data !== 16'h0 || i_beat !== 3'd0) begin
         errors++;
         $display("FAIL midrst_outputs: ctl=%b addr=%h idata=%h ibeat=%0d, required all 0",
                  {mem_en, mem_wr, i_gnt, d_gnt, i_vld, d_vld, i_done, d_done, busy}, mem_addr, i_data, i_beat);
      end
      sb.delete();
      rst = 1'b0;
      i_addr = 16'h4100; i_req = 1'b1;
      push_burst(1'b0, 16'h4100);
      collect_burst(1'b0, 16'h4100, 40);
   endtask

   task automatic test_stray_vld;
      stray = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (i_vld !== 1'b0 || d_vld !== 1'b0 || busy !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL stray_vld cyc%0d: i_vld=%b d_vld=%b busy=%b, required 0 0 0", c, i_vld, d_vld, busy);
         end
      end
      stray = 1'b0;
      lat = 3;
      i_addr = 16'h5670; i_req = 1'b1;
      push_burst(1'b0, 16'h5670);
      collect_burst(1'b0, 16'h5670, 40);
   endtask

   initial begin
      mem_vld = 1'b0;
      mem_rdata = 16'h0;
      test_reset();
      test_contention();
      test_i_read();
      test_d_write();
      test_round_robin();
      test_gapped();
      test_reset_mid_burst();
      test_stray_vld();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
